fixed_add_arbiter: RTL and testbench

Shares one sign-magnitude fixed-point adder between `NREQ` requesters with round-robin fairness and valid/ready handshakes on both sides. Each accepted request is added combinationally and registered into a single-entry response buffer tagged with the requester index. It sits between the fixed-point compute clients and the shared adder datapath. It sustains one addition per cycle when the response side never stalls.

---
 rtl/fixed_point_pkg.sv | 19 +
 rtl/sm_adder_core.sv | 41 ++++
 rtl/fixed_add_arbiter.sv | 107 ++++++++++
 tb/tb_fixed_add_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the sign-magnitude fixed-point arbiter: response
// buffer state encoding and sign/magnitude field helpers.
package fixed_point_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    // Width-generic helpers; callers zero-extend the word and size-cast the result.
    function automatic logic sm_sign(input logic [63:0] w, input int unsigned n);
        return w[n-1];
    endfunction

    function automatic logic [63:0] sm_mag(input logic [63:0] w, input int unsigned n);
        return w & ((64'd1 << (n - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/sm_adder_core.sv
// Combinational sign-magnitude adder; ovf flags magnitude carry-out on a
// same-sign add, and equal-magnitude cancellation always yields +0.
module sm_adder_core
    import fixed_point_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         ovf
);

    localparam int unsigned MW = N - 1;

    logic          sa;
    logic          sb;
    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic [MW:0]   s_add;

    assign sa = sm_sign(64'(a), N);
    assign sb = sm_sign(64'(b), N);
    assign ma = MW'(sm_mag(64'(a), N));
    assign mb = MW'(sm_mag(64'(b), N));

    always_comb begin
        sum   = '0;
        ovf   = 1'b0;
        s_add = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            sum = {sa, s_add[MW-1:0]};
            ovf = s_add[MW];
        end else if (ma > mb) begin
            sum = {sa, ma - mb};
        end else if (mb > ma) begin
            sum = {sb, mb - ma};
        end
    end

endmodule

// File: rtl/fixed_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder between NREQ
// requesters, with a single-entry tagged response buffer.
module fixed_add_arbiter
    import fixed_point_pkg::*;
#(
    parameter  int unsigned N    = 8,
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*N-1:0] i_req_a,
    input  logic [NREQ*N-1:0] i_req_b,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_rsp_valid,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [N-1:0]      o_rsp_sum,
    output logic              o_rsp_ovf,
    input  logic              i_rsp_ready
);

    rsp_state_t     state;
    rsp_state_t     state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] g;
    logic [IDW-1:0] rr_next;
    logic           found;
    logic           can_accept;
    logic           hs;
    logic [N-1:0]   a_sel;
    logic [N-1:0]   b_sel;
    logic [N-1:0]   add_sum;
    logic           add_ovf;

    // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!found && i_req_valid[IDW'(idx)]) begin
                found = 1'b1;
                g     = IDW'(idx);
            end
        end
    end

    assign can_accept = (state == EMPTY) || i_rsp_ready;
    assign hs         = can_accept && found && !i_rst;
    assign rr_next    = (32'(g) == NREQ - 1) ? '0 : g + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (hs) begin
            o_req_ready[g] = 1'b1;
        end
    end

    assign a_sel = i_req_a[32'(g)*N +: N];
    assign b_sel = i_req_b[32'(g)*N +: N];

    sm_adder_core #(.N(N)) u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (hs) state_nx = FULL;
            FULL: begin
                if (hs)               state_nx = FULL;
                else if (i_rsp_ready) state_nx = EMPTY;
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr    <= '0;
            o_rsp_id  <= '0;
            o_rsp_sum <= '0;
            o_rsp_ovf <= 1'b0;
        end else if (hs) begin
            rr_ptr    <= rr_next;
            o_rsp_id  <= g;
            o_rsp_sum <= add_sum;
            o_rsp_ovf <= add_ovf;
        end
    end

    assign o_rsp_valid = (state == FULL);

endmodule

// File: tb/tb_fixed_add_arbiter.sv
// Directed bench for fixed_add_arbiter: adder vector table on one requester
// plus hand-written round-robin, stall, fairness and async-reset sequences.
module tb_fixed_add_arbiter;

    localparam int unsigned N    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*N-1:0] i_req_a;
    logic [NREQ*N-1:0] i_req_b;
    logic [NREQ-1:0]   o_req_ready;
    logic              o_rsp_valid;
    logic [IDW-1:0]    o_rsp_id;
    logic [N-1:0]      o_rsp_sum;
    logic              o_rsp_ovf;
    logic              i_rsp_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    fixed_add_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_sum   (o_rsp_sum),
        .o_rsp_ovf   (o_rsp_ovf),
        .i_rsp_ready (i_rsp_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Advance past one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk_rsp(input string name, input logic [1:0] id, input logic [7:0] sum,
                           input logic ovf);
        chk({name, ".valid"}, 32'(o_rsp_valid), 32'd1);
        chk({name, ".id"},    32'(o_rsp_id),    32'(id));
        chk({name, ".sum"},   32'(o_rsp_sum),   32'(sum));
        chk({name, ".ovf"},   32'(o_rsp_ovf),   32'(ovf));
    endtask

    initial begin
        vecs[0] = '{a: 8'h85, b: 8'h03, sum: 8'h82, ovf: 1'b0};
        vecs[1] = '{a: 8'h05, b: 8'h85, sum: 8'h00, ovf: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h80, sum: 8'h80, ovf: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h01, sum: 8'h00, ovf: 1'b1};
        vecs[4] = '{a: 8'hFF, b: 8'h81, sum: 8'h80, ovf: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h05, sum: 8'h05, ovf: 1'b0};
        vecs[6] = '{a: 8'h03, b: 8'h8A, sum: 8'h87, ovf: 1'b0};
        vecs[7] = '{a: 8'h40, b: 8'h3F, sum: 8'h7F, ovf: 1'b0};

        i_rst       = 1'b1;
        i_req_valid = 4'b0001;
        i_req_a     = '0;
        i_req_b     = '0;
        i_rsp_ready = 1'b1;
        #1;
        chk("rst.valid", 32'(o_rsp_valid), 32'd0);
        chk("rst.id",    32'(o_rsp_id),    32'd0);
        chk("rst.sum",   32'(o_rsp_sum),   32'd0);
        chk("rst.ovf",   32'(o_rsp_ovf),   32'd0);
        chk("rst.ready", 32'(o_req_ready), 32'd0);

        tick();
        i_rst       = 1'b0;
        i_req_valid = 4'b0000;
        tick();

        // First request on req0
        i_req_valid    = 4'b0001;
        i_req_a[7:0]   = 8'h05;
        i_req_b[7:0]   = 8'h83;
        #1;
        chk("first.ready", 32'(o_req_ready), 32'b0001);
        tick();
        i_req_valid = 4'b0000;
        #1;
        chk_rsp("first", 2'd0, 8'h02, 1'b0);
        chk("first.ready_after", 32'(o_req_ready), 32'd0);

        // Adder table on req1
        for (int i = 0; i < 8; i++) begin
            i_req_valid   = 4'b0010;
            i_req_a[15:8] = vecs[i].a;
            i_req_b[15:8] = vecs[i].b;
            #1;
            chk($sformatf("vec%0d.ready", i), 32'(o_req_ready), 32'b0010);
            tick();
            i_req_valid = 4'b0000;
            #1;
            chk_rsp($sformatf("vec%0d", i), 2'd1, vecs[i].sum, vecs[i].ovf);
        end
        tick();
        chk("drain.valid", 32'(o_rsp_valid), 32'd0);

        // Reset so round-robin starts from pointer 0
        i_rst = 1'b1;
        #1;
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_req_a[k*8 +: 8] = 8'(k + 1);
            i_req_b[k*8 +: 8] = 8'h10;
        end
        i_req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rr%0d.ready", c), 32'(o_req_ready), 32'(1 << (c % 4)));
            tick();
            #1;
            chk_rsp($sformatf("rr%0d", c), 2'(c % 4), 8'(8'h11 + (c % 4)), 1'b0);
        end

        // Stall with all requests pending; buffer holds id 3
        i_rsp_ready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d.ready", s), 32'(o_req_ready), 32'd0);
            chk_rsp($sformatf("stall%0d", s), 2'd3, 8'h14, 1'b0);
            tick();
            #1;
        end
        i_rsp_ready = 1'b1;
        #1;
        chk("release.ready", 32'(o_req_ready), 32'b0001);
        tick();
        #1;
        chk_rsp("release", 2'd0, 8'h11, 1'b0);

        // Pointer is 1: grant req1 alone to move it to 2
        i_req_valid = 4'b0010;
        #1;
        chk("ptr.ready1", 32'(o_req_ready), 32'b0010);
        tick();
        i_req_valid = 4'b1001;
        #1;
        chk("fair.ready3", 32'(o_req_ready), 32'b1000);
        tick();
        #1;
        chk_rsp("fair3", 2'd3, 8'h14, 1'b0);
        chk("fair.ready0", 32'(o_req_ready), 32'b0001);
        tick();
        i_rsp_ready = 1'b0;
        #1;
        chk_rsp("fair0", 2'd0, 8'h11, 1'b0);

        // Async reset while FULL, mid-cycle
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst.valid", 32'(o_rsp_valid), 32'd0);
        chk("arst.sum",   32'(o_rsp_sum),   32'd0);
        chk("arst.ready", 32'(o_req_ready), 32'd0);
        tick();
        i_rst       = 1'b0;
        i_rsp_ready = 1'b1;
        i_req_valid = 4'b1010;
        #1;
        chk("post_rst.ready", 32'(o_req_ready), 32'b0010);
        tick();
        i_req_valid = 4'b0000;
        #1;
        chk_rsp("post_rst", 2'd1, 8'h12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
